// File: rtl/elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl
//
// Single-car elevator controller with SCAN (collective) scheduling. Floor
// requests accumulate in a per-floor pending bitmap. The car keeps travelling
// in its current direction while there is work ahead of it, and stops at
// every pending floor it reaches. It reverses only when nothing is left in
// the current direction.
//
// Parameters
//   NUM_FLOORS    number of floors (valid indices 0..NUM_FLOORS-1)
//   FLOOR_W       width of floor index buses
//   TRAVEL_CYCLES clock cycles needed to move one floor (>= 1)
//   DOOR_CYCLES   door dwell in cycles when nothing holds the door (>= 2)
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset         synchronous active-high reset
//   req_valid     one-cycle request strobe
//   req_floor     requested floor; out-of-range values are dropped
//   sensor        door obstruction, keeps the door open while high
//   door_hold     door-open button, keeps the door open while high
//   current_floor car position
//   direction     travel preference (1 = up, 0 = down)
//   moving        car is travelling (MOVE_UP / MOVE_DOWN)
//   door_open     door is open (DOOR_OPEN)
//   pending       outstanding request bitmap
//
// Every output comes straight from a register. There is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 16,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  sensor,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  // A one-cycle travel time still needs a 1-bit counter so that the
  // declaration stays legal.
  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = $clog2(DOOR_CYCLES);

  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_t;

  state_t                  state_reg,      state_next;
  logic [FLOOR_W-1:0]      floor_reg,      floor_next;
  logic                    dir_reg,        dir_next;
  logic [NUM_FLOORS-1:0]   pending_reg,    pending_next;
  logic [TRAVEL_W-1:0]     travel_cnt_reg, travel_cnt_next;
  logic [DOOR_W-1:0]       door_cnt_reg,   door_cnt_next;
  logic                    moving_reg;
  logic                    door_open_reg;

  // -------------------------------------------------------------------------
  // Per-floor decode
  //   floor_onehot : the car's floor as a one-hot mask
  //   req_onehot   : the incoming request as a one-hot mask. An out-of-range
  //                  floor matches no bit, so it is dropped here.
  //   above/below  : pending floors strictly above/below the car
  // -------------------------------------------------------------------------
  logic [NUM_FLOORS-1:0] floor_onehot;
  logic [NUM_FLOORS-1:0] req_onehot;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign floor_onehot[gi] = (floor_reg == FLOOR_W'(gi));
      assign req_onehot[gi]   = req_valid && (req_floor == FLOOR_W'(gi));
      assign above_mask[gi]   = pending_reg[gi] && (FLOOR_W'(gi) > floor_reg);
      assign below_mask[gi]   = pending_reg[gi] && (FLOOR_W'(gi) < floor_reg);
    end
  endgenerate

  logic here_pending;   // a request waits at the car's current floor
  logic any_above;
  logic any_below;
  logic req_here;       // incoming request targets the car's current floor
  logic ahead_pending;  // more work in the current travel direction
  logic clear_here;     // current floor counts as served this cycle

  assign here_pending  = |(pending_reg & floor_onehot);
  assign any_above     = |above_mask;
  assign any_below     = |below_mask;
  assign req_here      = |(req_onehot & floor_onehot);
  assign ahead_pending = (state_reg == ST_MOVE_UP) ? any_above : any_below;

  // The floor is served on the edge that enters DOOR_OPEN and for as long as
  // the door stays open. In IDLE or MOVE a pending bit at the current floor
  // always leads into DOOR_OPEN, so here_pending covers the entering edge.
  assign clear_here = here_pending || (state_reg == ST_DOOR_OPEN);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    floor_next      = floor_reg;
    dir_next        = dir_reg;
    travel_cnt_next = travel_cnt_reg;
    door_cnt_next   = door_cnt_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (here_pending) begin
          state_next    = ST_DOOR_OPEN;
          door_cnt_next = '0;
        end else if (any_above && (dir_reg || !any_below)) begin
          // If there is work both ways, keep the current direction.
          state_next      = ST_MOVE_UP;
          dir_next        = 1'b1;
          travel_cnt_next = '0;
        end else if (any_below) begin
          state_next      = ST_MOVE_DOWN;
          dir_next        = 1'b0;
          travel_cnt_next = '0;
        end
      end

      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (here_pending) begin
          state_next      = ST_DOOR_OPEN;
          travel_cnt_next = '0;
          door_cnt_next   = '0;
        end else if (!ahead_pending) begin
          // Nothing left this way. IDLE will decide whether to reverse.
          state_next      = ST_IDLE;
          travel_cnt_next = '0;
        end else if (travel_cnt_reg == TRAVEL_LAST) begin
          // ahead_pending is never set at an end floor, so the step
          // cannot leave 0..NUM_FLOORS-1.
          travel_cnt_next = '0;
          if (state_reg == ST_MOVE_UP) begin
            floor_next = floor_reg + FLOOR_W'(1);
          end else begin
            floor_next = floor_reg - FLOOR_W'(1);
          end
        end else begin
          travel_cnt_next = travel_cnt_reg + TRAVEL_W'(1);
        end
      end

      ST_DOOR_OPEN: begin
        if (sensor || door_hold || req_here) begin
          // Any hold, or another call for this floor, restarts the dwell.
          door_cnt_next = '0;
        end else if (door_cnt_reg == DOOR_LAST) begin
          state_next    = ST_IDLE;
          door_cnt_next = '0;
        end else begin
          door_cnt_next = door_cnt_reg + DOOR_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // When a request for the current floor arrives in the same cycle as the
    // clear, the clear wins and the request counts as served.
    pending_next = (pending_reg | req_onehot) &
                   ~(clear_here ? floor_onehot : {NUM_FLOORS{1'b0}});
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      floor_reg      <= '0;
      dir_reg        <= 1'b1;
      pending_reg    <= '0;
      travel_cnt_reg <= '0;
      door_cnt_reg   <= '0;
      moving_reg     <= 1'b0;
      door_open_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      floor_reg      <= floor_next;
      dir_reg        <= dir_next;
      pending_reg    <= pending_next;
      travel_cnt_reg <= travel_cnt_next;
      door_cnt_reg   <= door_cnt_next;
      moving_reg     <= (state_next == ST_MOVE_UP) || (state_next == ST_MOVE_DOWN);
      door_open_reg  <= (state_next == ST_DOOR_OPEN);
    end
  end

  assign current_floor = floor_reg;
  assign direction     = dir_reg;
  assign moving        = moving_reg;
  assign door_open     = door_open_reg;
  assign pending       = pending_reg;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for elevator_scan_ctrl.
//
// NUM_FLOORS is 12 with a 4-bit floor bus, so floors 12..15 can be driven
// as out-of-range requests. The reference model keeps the car as a floor
// number, a travel direction, a coarse mode, and countdowns to the next floor
// step and to the door closing. A negedge process compares every output
// against the model each cycle. Directed scenarios also pin known values.
// ---------------------------------------------------------------------------
module tb_elevator_scan_ctrl;

  localparam int NF = 12;
  localparam int FW = 4;
  localparam int TC = 4;
  localparam int DC = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          sensor = 1'b0;
  logic          door_hold = 1'b0;
  logic [FW-1:0] current_floor;
  logic          direction;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;

  always #5 clk = ~clk;

  elevator_scan_ctrl #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES  (DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .sensor       (sensor),
    .door_hold    (door_hold),
    .current_floor(current_floor),
    .direction    (direction),
    .moving       (moving),
    .door_open    (door_open),
    .pending      (pending)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference model. Modes: 0 = waiting, 1 = travelling, 2 = door open.
  int          m_floor;
  bit          m_dir;
  logic [NF-1:0] m_pend;
  int          m_mode;
  int          m_travel_left;
  int          m_door_left;

  // Floors where the door opened and the direction at that moment.
  int door_log[$];
  int dir_log[$];
  bit prev_door = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit rst, bit rv, int rf, bit sen, bit hold);
    bit here, above, below, ahead, served;
    int old_floor;
    if (rst) begin
      m_floor = 0; m_dir = 1'b1; m_pend = '0; m_mode = 0;
      m_travel_left = 0; m_door_left = 0;
      return;
    end
    old_floor = m_floor;
    here  = m_pend[m_floor];
    above = 1'b0;
    below = 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (m_pend[f] && f > m_floor) above = 1'b1;
      if (m_pend[f] && f < m_floor) below = 1'b1;
    end
    served = here || (m_mode == 2);
    case (m_mode)
      0: begin
        if (here) begin
          m_mode = 2; m_door_left = DC;
        end else if (above && (m_dir || !below)) begin
          m_mode = 1; m_dir = 1'b1; m_travel_left = TC;
        end else if (below) begin
          m_mode = 1; m_dir = 1'b0; m_travel_left = TC;
        end
      end
      1: begin
        ahead = m_dir ? above : below;
        if (here) begin
          m_mode = 2; m_door_left = DC;
        end else if (!ahead) begin
          m_mode = 0;
        end else begin
          m_travel_left--;
          if (m_travel_left == 0) begin
            m_floor += m_dir ? 1 : -1;
            m_travel_left = TC;
          end
        end
      end
      default: begin
        if (sen || hold || (rv && rf == m_floor)) m_door_left = DC;
        else if (m_door_left == 1) m_mode = 0;
        else m_door_left--;
      end
    endcase
    if (rv && rf < NF) m_pend[rf] = 1'b1;
    if (served) m_pend[old_floor] = 1'b0;
  endfunction

  // Single compare process: every output against the model, once per cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_floor",     32'(current_floor), 32'(m_floor));
      chk("model_direction", 32'(direction),     32'(m_dir));
      chk("model_moving",    32'(moving),        32'(m_mode == 1));
      chk("model_door_open", 32'(door_open),     32'(m_mode == 2));
      chk("model_pending",   32'(pending),       32'(m_pend));
    end
  end

  task automatic tick(bit rst, bit rv, int rf, bit sen, bit hold);
    reset     = rst;
    req_valid = rv;
    req_floor = FW'(rf);
    sensor    = sen;
    door_hold = hold;
    @(posedge clk);
    model_step(rst, rv, rf, sen, hold);
    #1;
    req_valid = 1'b0;
    if (door_open && !prev_door) begin
      door_log.push_back(int'(current_floor));
      dir_log.push_back(int'(direction));
    end
    prev_door = door_open;
  endtask

  task automatic idle(int n);
    repeat (n) tick(0, 0, 0, 0, 0);
  endtask

  // Run until the car sits idle with nothing pending; an expired budget fails.
  task automatic settle(string name, int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (pending == '0 && !moving && !door_open) begin
        done = 1'b1;
        break;
      end
      tick(0, 0, 0, 0, 0);
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_floor(string name, int f, int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (moving && int'(current_floor) == f) begin
        done = 1'b1;
        break;
      end
      tick(0, 0, 0, 0, 0);
    end
    chk(name, 32'(done), 32'd1);
  endtask

  function automatic int log_at(int i);
    return (i < door_log.size()) ? door_log[i] : 99;
  endfunction

  function automatic int dlog_at(int i);
    return (i < dir_log.size()) ? dir_log[i] : 99;
  endfunction

  initial begin
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check_en = 1'b1;

    // Reset state
    chk("rst_floor",   32'(current_floor), 32'd0);
    chk("rst_dir",     32'(direction),     32'd1);
    chk("rst_pending", 32'(pending),       32'd0);
    chk("rst_moving",  32'(moving),        32'd0);
    chk("rst_door",    32'(door_open),     32'd0);

    // Reset overrides a same-cycle request
    tick(1, 1, 5, 0, 0);
    chk("rst_req_pending", 32'(pending), 32'd0);

    // Basic trip 0 -> 3 (request at edge 0)
    tick(0, 1, 3, 0, 0);
    chk("basic_pend_set", 32'(pending), 32'h008);
    chk("basic_not_yet_moving", 32'(moving), 32'd0);
    idle(1);                                            // edge 1
    chk("basic_move_e1", 32'(moving), 32'd1);
    idle(3);                                            // edge 4
    chk("basic_floor_e4", 32'(current_floor), 32'd0);
    idle(1);                                            // edge 5
    chk("basic_floor_e5", 32'(current_floor), 32'd1);
    idle(4);                                            // edge 9
    chk("basic_floor_e9", 32'(current_floor), 32'd2);
    idle(4);                                            // edge 13
    chk("basic_floor_e13", 32'(current_floor), 32'd3);
    chk("basic_door_e13", 32'(door_open), 32'd0);
    idle(1);                                            // edge 14
    chk("basic_door_e14", 32'(door_open), 32'd1);
    chk("basic_pend_clr", 32'(pending), 32'd0);
    idle(31);                                           // edge 45
    chk("basic_door_e45", 32'(door_open), 32'd1);
    idle(1);                                            // edge 46
    chk("basic_door_e46", 32'(door_open), 32'd0);
    chk("basic_idle_end", 32'(moving), 32'd0);

    // Out-of-range floors are dropped
    tick(0, 1, 12, 0, 0);
    chk("oor_12", 32'(pending), 32'd0);
    tick(0, 1, 15, 0, 0);
    chk("oor_15", 32'(pending), 32'd0);
    idle(2);
    chk("oor_no_move", 32'(moving), 32'd0);

    // Request for the current floor while idle; sensor re-arm at timer 20
    tick(0, 1, 3, 0, 0);
    chk("here_pend", 32'(pending), 32'h008);
    idle(1);
    chk("here_door", 32'(door_open), 32'd1);
    chk("here_floor", 32'(current_floor), 32'd3);
    chk("here_no_move", 32'(moving), 32'd0);
    idle(20);
    repeat (10) tick(0, 0, 0, 1, 0);
    idle(31);
    chk("sensor_door_61", 32'(door_open), 32'd1);
    idle(1);
    chk("sensor_door_62", 32'(door_open), 32'd0);

    // Same-floor request during DOOR_OPEN restarts the dwell
    tick(0, 1, 3, 0, 0);
    idle(1);
    idle(10);
    tick(0, 1, 3, 0, 0);
    chk("rearm_req_pend", 32'(pending), 32'd0);
    idle(31);
    chk("rearm_door_42", 32'(door_open), 32'd1);
    idle(1);
    chk("rearm_door_43", 32'(door_open), 32'd0);

    // door_hold keeps the door open as well
    tick(0, 1, 3, 0, 0);
    idle(1);
    repeat (40) tick(0, 0, 0, 0, 1);
    chk("hold_door", 32'(door_open), 32'd1);
    settle("hold_settle", 200);

    // SCAN ordering: heading up to 7, at floor 5 request 2 then 9
    tick(0, 1, 7, 0, 0);
    wait_floor("scan_reach5", 5, 100);
    door_log.delete();
    dir_log.delete();
    tick(0, 1, 2, 0, 0);
    tick(0, 1, 9, 0, 0);
    settle("scan_settle", 600);
    chk("scan_stops", 32'(door_log.size()), 32'd3);
    chk("scan_stop0", 32'(log_at(0)), 32'd7);
    chk("scan_stop1", 32'(log_at(1)), 32'd9);
    chk("scan_stop2", 32'(log_at(2)), 32'd2);
    chk("scan_dir0",  32'(dlog_at(0)), 32'd1);
    chk("scan_dir1",  32'(dlog_at(1)), 32'd1);
    chk("scan_dir2",  32'(dlog_at(2)), 32'd0);

    // Pickup en route: from 0 toward 8, request 4 at floor 2
    tick(0, 1, 0, 0, 0);
    settle("pick_home", 300);
    tick(0, 1, 8, 0, 0);
    wait_floor("pick_reach2", 2, 100);
    door_log.delete();
    dir_log.delete();
    tick(0, 1, 4, 0, 0);
    settle("pick_settle", 400);
    chk("pick_stops", 32'(door_log.size()), 32'd2);
    chk("pick_stop0", 32'(log_at(0)), 32'd4);
    chk("pick_stop1", 32'(log_at(1)), 32'd8);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(999) == 0),
           ($urandom_range(5) == 0),
           int'($urandom_range(15)),
           ($urandom_range(19) == 0),
           ($urandom_range(24) == 0));
    end
    settle("rand_settle", 2000);

    // Reset while moving up at floor 6
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 11, 0, 0);
    wait_floor("rstmv_reach6", 6, 100);
    tick(1, 0, 0, 0, 0);
    chk("rstmv_floor",   32'(current_floor), 32'd0);
    chk("rstmv_moving",  32'(moving),        32'd0);
    chk("rstmv_pending", 32'(pending),       32'd0);
    chk("rstmv_door",    32'(door_open),     32'd0);
    chk("rstmv_dir",     32'(direction),     32'd1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
# elevator_scan_ctrl

Parametrised single-car elevator controller: next generation of the FIFO-order controller, generalised to NUM_FLOORS floors with SCAN (collective) scheduling. Requests are held in a per-floor pending bitmap and served in travel-direction order, with a configurable floor-travel time, a configurable door dwell, and door-hold/obstruction re-arm. Sits between the floor-request input logic and the car/door drive, one instance per car.

## Interface

- NUM_FLOORS, 16: number of floors, valid floor indices 0..NUM_FLOORS-1; range 2..2^FLOOR_W.
- FLOOR_W, 4: width of floor index buses.
- TRAVEL_CYCLES, 4: clock cycles to move one floor; range ≥1.
- DOOR_CYCLES, 32: door dwell in cycles with no hold; range ≥2.
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  one-cycle floor request strobe.
- req_floor  in  FLOOR_W  requested floor, sampled when req_valid=1.
- sensor  in  1  door obstruction; holds the door open while high.
- door_hold  in  1  door-open button; holds the door open while high.
- current_floor  out  FLOOR_W  car position.
- direction  out  1  travel preference: 1=up, 0=down.
- moving  out  1  high in MOVE_UP/MOVE_DOWN.
- door_open  out  1  high in DOOR_OPEN.
- pending  out  NUM_FLOORS  outstanding request bitmap.

## Operation

- Request capture: req_valid with req_floor < NUM_FLOORS sets pending[req_floor]; out-of-range floors are silently dropped. Duplicate requests are idempotent.
- Clear: pending[current_floor] is cleared on the edge that enters DOOR_OPEN and is held cleared while in DOOR_OPEN. A same-cycle request for that floor is treated as served (clear wins); in DOOR_OPEN it restarts the door timer.
- above = any pending bit > current_floor; below = any pending bit < current_floor.
- IDLE: if pending[current_floor] → DOOR_OPEN. Else if above and (direction=1 or !below) → MOVE_UP, direction=1. Else if below → MOVE_DOWN, direction=0. Else stay. Tie (above and below): keep current direction.
- MOVE_UP/MOVE_DOWN, evaluated each cycle: if pending[current_floor] → DOOR_OPEN, travel counter cleared. Else if no requests ahead in the travel direction → IDLE. Else travel counter increments. When the counter reaches TRAVEL_CYCLES-1, current_floor steps ±1 and the counter returns to 0.
- Floor never leaves 0..NUM_FLOORS-1, because "ahead" is empty at the end floors.
- DOOR_OPEN: door timer counts 0..DOOR_CYCLES-1. Any of the following resets the timer to 0: sensor, door_hold, or req_valid for current_floor. At DOOR_CYCLES-1 with none of these asserted → IDLE, timer cleared.
- Reset: state IDLE, current_floor=0, direction=1, pending=0, both counters 0. Hence moving=0 and door_open=0. Reset mid-move or mid-door drops all requests; reset overrides a same-cycle req_valid.

## Timing

- Request sampled at edge k is visible on pending after edge k. The IDLE decision uses it at edge k+1.
- If the car is at the requested floor and IDLE, door_open rises after edge k+1.
- A move begins after edge k+1. The floor changes TRAVEL_CYCLES edges after entering MOVE, then every TRAVEL_CYCLES edges.
- Arrival at a pending floor: DOOR_OPEN one edge after current_floor updates.
- door_open stays high for exactly DOOR_CYCLES cycles with no hold. Every hold cycle extends it, with the count restarting from 0 after the last hold cycle.
- All outputs are registered or decoded directly from registered state; there is no combinational path from inputs to outputs.

## Test plan

- Reset/basic: TRAVEL_CYCLES=4, DOOR_CYCLES=32. Request floor 3 at cycle 0 (edge 0) from floor 0 → MOVE_UP after edge 1; floor 1/2/3 after edges 5/9/13; door_open after edge 14 for 32 cycles; pending[3] cleared; then IDLE.
- SCAN order: at floor 5 moving up, request 2 then 9 → car stops at 9 first, reverses, then stops at 2. direction is 1 during the up leg and 0 during the down leg.
- Pickup en route: moving up from 0 toward 8, request 4 arrives while the car is at floor 2 → car stops at 4 (door opens), then continues to 8.
- Door re-arm: in DOOR_OPEN, assert sensor for 10 cycles at timer=20 → door_open lasts 20+10+32 cycles. Also, a request for current_floor restarts the timer and leaves pending unchanged.
- Boundaries: req_floor=NUM_FLOORS → ignored. A request for the current floor while IDLE → door opens with no movement. Simultaneous reset and req_valid → pending=0.
- Reset mid-move: assert reset while in MOVE_UP at floor 6 → next cycle floor 0, IDLE, pending 0, door_open 0.
